// File: rtl/alu_arbiter_seq.sv
// Round-robin arbiter that shares one combinational ALU among NREQ requesters.
// The winning op is latched, run through the ALU for one cycle, and returned with its requester id.
module alu_arbiter_seq #(
  parameter int NREQ = 2,
  parameter int ID_W = $clog2(NREQ),
  parameter int XLEN = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NREQ-1:0]      req_valid_i,
  output logic [NREQ-1:0]      req_ready_o,
  input  logic [NREQ*7-1:0]    req_opcode_i,
  input  logic [NREQ*3-1:0]    req_func3_i,
  input  logic [NREQ*7-1:0]    req_func7_i,
  input  logic [NREQ*XLEN-1:0] req_a_i,
  input  logic [NREQ*XLEN-1:0] req_b_i,
  input  logic [NREQ*XLEN-1:0] req_imm_i,
  output logic [6:0]           alu_opcode_o,
  output logic [2:0]           alu_func3_o,
  output logic [6:0]           alu_func7_o,
  output logic [XLEN-1:0]      alu_a_o,
  output logic [XLEN-1:0]      alu_b_o,
  output logic [XLEN-1:0]      alu_imm_o,
  input  logic [XLEN-1:0]      alu_result_i,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [ID_W-1:0]      rsp_id_o,
  output logic [XLEN-1:0]      rsp_result_o,
  output logic                 rsp_err_o,
  output logic [31:0]          op_count_o
);

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] last_q, last_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;
  logic [XLEN-1:0] rsp_result_q, rsp_result_d;
  logic            rsp_err_q, rsp_err_d;
  logic [31:0]     op_count_q, op_count_d;
  logic [6:0]      opcode_q, opcode_d;
  logic [2:0]      func3_q, func3_d;
  logic [6:0]      func7_q, func7_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] imm_q, imm_d;

  logic            any_valid;
  logic [ID_W-1:0] grant;
  logic            illegal;

  // Search starts one past the last winner so a lone requester is still found.
  always_comb begin
    int idx;
    any_valid = 1'b0;
    grant     = last_q;
    idx       = 0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(last_q) + k) % NREQ;
      if (!any_valid && req_valid_i[idx]) begin
        any_valid = 1'b1;
        grant     = ID_W'(idx);
      end
    end
  end

  assign illegal = !((opcode_q == OP_R) || (opcode_q == OP_I));

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;
    opcode_d     = opcode_q;
    func3_d      = func3_q;
    func7_d      = func7_q;
    a_d          = a_q;
    b_d          = b_q;
    imm_d        = imm_q;
    req_ready_o  = '0;
    case (state_q)
      IDLE: begin
        if (any_valid) begin
          req_ready_o[grant] = 1'b1;
          opcode_d = req_opcode_i[7*int'(grant) +: 7];
          func3_d  = req_func3_i[3*int'(grant) +: 3];
          func7_d  = req_func7_i[7*int'(grant) +: 7];
          a_d      = req_a_i[XLEN*int'(grant) +: XLEN];
          b_d      = req_b_i[XLEN*int'(grant) +: XLEN];
          imm_d    = req_imm_i[XLEN*int'(grant) +: XLEN];
          rsp_id_d = grant;
          last_d   = grant;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_result_d = illegal ? '0 : alu_result_i;
        rsp_err_d    = illegal;
        state_d      = RESP;
      end
      RESP: begin
        if (rsp_ready_i) begin
          op_count_d = op_count_q + 32'd1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      last_q       <= ID_W'(NREQ-1);
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
      opcode_q     <= '0;
      func3_q      <= '0;
      func7_q      <= '0;
      a_q          <= '0;
      b_q          <= '0;
      imm_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
      opcode_q     <= opcode_d;
      func3_q      <= func3_d;
      func7_q      <= func7_d;
      a_q          <= a_d;
      b_q          <= b_d;
      imm_q        <= imm_d;
    end
  end

  assign alu_opcode_o = opcode_q;
  assign alu_func3_o  = func3_q;
  assign alu_func7_o  = func7_q;
  assign alu_a_o      = a_q;
  assign alu_b_o      = b_q;
  assign alu_imm_o    = imm_q;
  assign rsp_valid_o  = (state_q == RESP);
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_err_o    = rsp_err_q;
  assign op_count_o   = op_count_q;

endmodule

// File: tb/tb_alu_arbiter_seq.sv
// Directed bench for alu_arbiter_seq with a small reference ALU on the alu_* side.
module tb_alu_arbiter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [13:0] req_opcode;
  logic [5:0]  req_func3;
  logic [13:0] req_func7;
  logic [63:0] req_a, req_b, req_imm;
  logic [6:0]  alu_opcode;
  logic [2:0]  alu_func3;
  logic [6:0]  alu_func7;
  logic [31:0] alu_a, alu_b, alu_imm, alu_result;
  logic        rsp_valid, rsp_ready;
  logic [0:0]  rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_err;
  logic [31:0] op_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_arbiter_seq #(.NREQ(2), .XLEN(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_opcode_i(req_opcode), .req_func3_i(req_func3), .req_func7_i(req_func7),
    .req_a_i(req_a), .req_b_i(req_b), .req_imm_i(req_imm),
    .alu_opcode_o(alu_opcode), .alu_func3_o(alu_func3), .alu_func7_o(alu_func7),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_imm_o(alu_imm),
    .alu_result_i(alu_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
    .rsp_id_o(rsp_id), .rsp_result_o(rsp_result), .rsp_err_o(rsp_err),
    .op_count_o(op_count)
  );

  // Reference ALU; non-ALU opcodes return a marker so a zeroed result is observable.
  always_comb begin
    alu_result = 32'hDEAD_BEEF;
    if (alu_opcode == 7'b0110011) begin
      case (alu_func3)
        3'b000:  alu_result = alu_func7[5] ? alu_a - alu_b : alu_a + alu_b;
        3'b111:  alu_result = alu_a & alu_b;
        3'b110:  alu_result = alu_a | alu_b;
        3'b100:  alu_result = alu_a ^ alu_b;
        default: alu_result = alu_a + alu_b;
      endcase
    end else if (alu_opcode == 7'b0010011) begin
      case (alu_func3)
        3'b111:  alu_result = alu_a & alu_imm;
        3'b110:  alu_result = alu_a | alu_imm;
        3'b100:  alu_result = alu_a ^ alu_imm;
        default: alu_result = alu_a + alu_imm;
      endcase
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm);
    req_valid[i]           = v;
    req_opcode[7*i +: 7]   = op;
    req_func3[3*i +: 3]    = f3;
    req_func7[7*i +: 7]    = f7;
    req_a[32*i +: 32]      = a;
    req_b[32*i +: 32]      = b;
    req_imm[32*i +: 32]    = imm;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (req_ready == 2'b00 && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_ready_seen"}, 32'(req_ready != 2'b00), 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (!rsp_valid && n < 10) begin
      step();
      n++;
    end
    chk({tag, "_rsp_seen"}, 32'(rsp_valid), 32'd1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_opcode = '0;
    req_func3  = '0;
    req_func7  = '0;
    req_a      = '0;
    req_b      = '0;
    req_imm    = '0;
    rsp_ready  = 1'b1;
    step();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_op_count", op_count, 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    rst = 1'b0;

    // 1: single ADD from req0, two edges to response
    step();
    set_req(0, 1'b1, 7'b0110011, 3'b000, 7'b0000000, 32'd10, 32'd5, 32'd0);
    #1;
    chk("t1_ready", 32'(req_ready), 32'd1);
    step();
    req_valid[0] = 1'b0;
    #1;
    chk("t1_exec_ready", 32'(req_ready), 32'd0);
    chk("t1_exec_valid", 32'(rsp_valid), 32'd0);
    chk("t1_alu_opcode", 32'(alu_opcode), 32'h33);
    chk("t1_alu_a", alu_a, 32'd10);
    chk("t1_alu_b", alu_b, 32'd5);
    step();
    chk("t1_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("t1_rsp_id", 32'(rsp_id), 32'd0);
    chk("t1_rsp_result", rsp_result, 32'd15);
    chk("t1_rsp_err", 32'(rsp_err), 32'd0);
    step();
    chk("t1_after_valid", 32'(rsp_valid), 32'd0);
    chk("t1_op_count", op_count, 32'd1);
    chk("t1_alu_hold", alu_a, 32'd10);

    // 2: both requesters continuously valid, grants alternate from 0 after reset
    pulse_rst();
    set_req(0, 1'b1, 7'b0110011, 3'b000, 7'b0100000, 32'd10, 32'd5, 32'd0);
    set_req(1, 1'b1, 7'b0010011, 3'b000, 7'b0000000, 32'd10, 32'd0, 32'd5);
    #1;
    for (int k = 0; k < 4; k++) begin
      wait_ready("t2");
      chk("t2_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      step();
      wait_rsp("t2");
      chk("t2_rsp_id", 32'(rsp_id), (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("t2_rsp_result", rsp_result, (k % 2 == 0) ? 32'd5 : 32'd15);
      step();
    end
    req_valid = '0;
    #1;
    chk("t2_op_count", op_count, 32'd4);

    // 3: backpressure on AND 12&5 with both requesters waiting
    rsp_ready = 1'b0;
    set_req(0, 1'b1, 7'b0110011, 3'b111, 7'b0000000, 32'd12, 32'd5, 32'd0);
    #1;
    chk("t3_ready", 32'(req_ready), 32'd1);
    step();
    set_req(1, 1'b1, 7'b0110011, 3'b000, 7'b0000000, 32'd1, 32'd1, 32'd0);
    #1;
    wait_rsp("t3");
    for (int k = 0; k < 5; k++) begin
      chk("t3_bp_valid", 32'(rsp_valid), 32'd1);
      chk("t3_bp_result", rsp_result, 32'd4);
      chk("t3_bp_ready", 32'(req_ready), 32'd0);
      step();
    end
    chk("t3_bp_count", op_count, 32'd4);
    req_valid = '0;
    rsp_ready = 1'b1;
    step();
    chk("t3_after_valid", 32'(rsp_valid), 32'd0);
    chk("t3_op_count", op_count, 32'd5);

    // 4: illegal opcode from lone req0 (last winner was also 0)
    set_req(0, 1'b1, 7'b0000011, 3'b000, 7'b0000000, 32'd7, 32'd0, 32'd0);
    #1;
    chk("t4_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    wait_rsp("t4");
    chk("t4_rsp_err", 32'(rsp_err), 32'd1);
    chk("t4_rsp_result", rsp_result, 32'd0);
    step();
    chk("t4_op_count", op_count, 32'd6);

    // 5: async reset while a response is pending
    rsp_ready = 1'b0;
    set_req(1, 1'b1, 7'b0110011, 3'b000, 7'b0000000, 32'd3, 32'd4, 32'd0);
    #1;
    chk("t5_ready", 32'(req_ready), 32'd2);
    step();
    req_valid = '0;
    wait_rsp("t5");
    chk("t5_rsp_result", rsp_result, 32'd7);
    #2;
    rst = 1'b1;
    #1;
    chk("t5_rst_valid", 32'(rsp_valid), 32'd0);
    chk("t5_rst_count", op_count, 32'd0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    step();
    chk("t5_no_stale", 32'(rsp_valid), 32'd0);
    set_req(0, 1'b1, 7'b0110011, 3'b000, 7'b0000000, 32'd20, 32'd2, 32'd0);
    set_req(1, 1'b1, 7'b0110011, 3'b000, 7'b0000000, 32'd30, 32'd3, 32'd0);
    #1;
    chk("t5_first_grant", 32'(req_ready), 32'd1);
    step();
    req_valid = '0;
    wait_rsp("t5b");
    chk("t5b_rsp_id", 32'(rsp_id), 32'd0);
    chk("t5b_rsp_result", rsp_result, 32'd22);
    step();
    chk("t5b_op_count", op_count, 32'd1);

    // 6: counter wrap from all-ones
    force dut.op_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.op_count_q;
    #1;
    chk("t6_preload", op_count, 32'hFFFF_FFFF);
    set_req(1, 1'b1, 7'b0010011, 3'b000, 7'b0000000, 32'd1, 32'd0, 32'd1);
    #1;
    chk("t6_ready", 32'(req_ready), 32'd2);
    step();
    req_valid = '0;
    wait_rsp("t6");
    chk("t6_rsp_result", rsp_result, 32'd2);
    step();
    chk("t6_wrap", op_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
